// File: rtl/obi_one_to_n_demux.sv
// rtl/obi_one_to_n_demux.sv - address-decoded OBI 1-to-N demultiplexer with in-order responses
// Unmapped addresses are answered by an internal error responder one cycle after grant.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_one_to_n_demux
  import obi_pkg::*;
#(
  parameter int unsigned          NSLAVE          = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter logic [NSLAVE*32-1:0] ADDR_BASE       = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVE*32-1:0] ADDR_MASK       = {NSLAVE{32'hF000_0000}},
  parameter logic [31:0]          ERR_RDATA       = 32'hBADC_AB1E,
  localparam int unsigned         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  obi_req_t         master_req_i,
  output obi_resp_t        master_resp_o,
  output obi_req_t         slave_req_o [NSLAVE],
  input  obi_resp_t        slave_resp_i [NSLAVE],
  output logic             err_unmapped_o,
  output logic [CW-1:0]    outstanding_o
);
  localparam int unsigned   TW      = $clog2(NSLAVE + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(NSLAVE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] cur_tgt_q, cur_tgt_d;
  logic          err_rvalid_q, err_rvalid_d;
  logic [TW-1:0] idx;
  logic          issue, hs, rvalid;
  logic          sel_gnt, sel_rvalid;
  logic [31:0]   sel_rdata;

  // Descending scan so the lowest matching slave wins.
  always_comb begin
    idx = ERR_IDX;
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if ((master_req_i.addr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
        idx = TW'(i);
      end
    end
  end

  // Holding the target until the count drains keeps responses in issue order.
  assign issue = master_req_i.req && !rst_i && (cnt_q < CW'(MAX_OUTSTANDING)) &&
                 ((cnt_q == '0) || (idx == cur_tgt_q));

  always_comb begin
    sel_gnt    = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (idx == TW'(i)) begin
        sel_gnt = slave_resp_i[i].gnt;
      end
      if (cur_tgt_q == TW'(i)) begin
        sel_rvalid = slave_resp_i[i].rvalid;
        sel_rdata  = slave_resp_i[i].rdata;
      end
    end
  end

  assign hs     = issue && ((idx == ERR_IDX) || sel_gnt);
  assign rvalid = !rst_i && ((cur_tgt_q == ERR_IDX) ? err_rvalid_q
                                                    : ((cnt_q != '0) && sel_rvalid));

  always_comb begin
    master_resp_o.gnt    = hs;
    master_resp_o.rvalid = rvalid;
    if (!rvalid) begin
      master_resp_o.rdata = '0;
    end else if (cur_tgt_q == ERR_IDX) begin
      master_resp_o.rdata = ERR_RDATA;
    end else begin
      master_resp_o.rdata = sel_rdata;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NSLAVE); i++) begin
      slave_req_o[i]     = master_req_i;
      slave_req_o[i].req = issue && (idx == TW'(i));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !rvalid) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!hs && rvalid) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign cur_tgt_d    = hs ? idx : cur_tgt_q;
  assign err_rvalid_d = hs && (idx == ERR_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      cur_tgt_q    <= '0;
      err_rvalid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_tgt_q    <= cur_tgt_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

  assign err_unmapped_o = err_rvalid_d;
  assign outstanding_o  = cnt_q;
endmodule

// File: tb/tb_obi_one_to_n_demux.sv
// tb/tb_obi_one_to_n_demux.sv - directed bench with an in-order transaction-queue reference model
module tb_obi_one_to_n_demux;
  import obi_pkg::*;

  localparam int NS   = 4;
  localparam int MAXO = 2;
  localparam int ERR  = 4;
  localparam logic [31:0] ERRD = 32'hBADC_AB1E;

  logic        clk = 1'b0;
  logic        rst;
  obi_req_t    mreq;
  obi_resp_t   mresp;
  obi_req_t    sreq [NS];
  obi_resp_t   sresp [NS];
  logic        err_un;
  logic [1:0]  outst;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_one_to_n_demux #(.NSLAVE(NS), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .master_req_i   (mreq),
    .master_resp_o  (mresp),
    .slave_req_o    (sreq),
    .slave_resp_i   (sresp),
    .err_unmapped_o (err_un),
    .outstanding_o  (outst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Default map: top nibble 0..3 selects that slave, anything else is unmapped.
  function automatic int dec(input logic [31:0] a);
    return (a[31:28] < 4'd4) ? int'(a[31:28]) : ERR;
  endfunction

  // Reference model: queue of targets of accepted, unanswered transactions, oldest first.
  int pend[$];
  bit err_prev;
  bit armed = 1'b0;

  always begin : compare
    int idx, n;
    bit allow, eg, ev;
    logic [31:0] ed;
    @(negedge clk);
    if (armed) begin
      n     = pend.size();
      idx   = dec(mreq.addr);
      allow = mreq.req && !rst && (n < MAXO) && ((n == 0) || (pend[n-1] == idx));
      eg    = allow && ((idx == ERR) ? 1'b1 : sresp[idx].gnt);
      ev    = !rst && (n > 0) && ((pend[0] == ERR) ? err_prev : sresp[pend[0]].rvalid);
      ed    = !ev ? 32'h0 : ((pend[0] == ERR) ? ERRD : sresp[pend[0]].rdata);
      chk("gnt", mresp.gnt, eg);
      chk("rvalid", mresp.rvalid, ev);
      chk("rdata", mresp.rdata, ed);
      chk("err_unmapped", err_un, eg && (idx == ERR));
      chk("outstanding", outst, n);
      for (int i = 0; i < NS; i++)
        chk($sformatf("slave%0d_req", i), sreq[i].req, allow && (idx == i));
      chk("slave_addr_fwd", sreq[NS-1].addr, mreq.addr);
      chk("slave_wdata_fwd", sreq[0].wdata, mreq.wdata);
      @(posedge clk);
      if (rst) begin
        pend.delete();
        err_prev = 1'b0;
      end else begin
        if (ev) void'(pend.pop_front());
        if (eg) pend.push_back(idx);
        err_prev = eg && (idx == ERR);
      end
    end else begin
      @(posedge clk);
      if (rst) begin
        pend.delete();
        err_prev = 1'b0;
        armed    = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      sresp[i].rvalid = 1'b0;
      sresp[i].rdata  = 32'h0;
    end
  endtask

  task automatic mset(input bit r, input bit w, input logic [31:0] a);
    mreq.req   = r;
    mreq.we    = w;
    mreq.be    = 4'hF;
    mreq.addr  = a;
    mreq.wdata = a ^ 32'h5A5A_5A5A;
  endtask

  task automatic srv(input int i, input logic [31:0] d);
    sresp[i].rvalid = 1'b1;
    sresp[i].rdata  = d;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mset(1'b1, 1'b0, 32'h4000_0000);
    for (int i = 0; i < NS; i++) sresp[i] = '{gnt: 1'b1, rvalid: 1'b0, rdata: 32'h0};
    tick(); tick(); settle();
    chk("rst_outstanding", outst, 0);
    chk("rst_gnt", mresp.gnt, 0);
    chk("rst_err", err_un, 0);
    rst = 1'b0;
    mset(1'b0, 1'b0, 32'h0);
    tick();

    // Single read to slave1, response two cycles after grant
    mset(1'b1, 1'b0, 32'h1000_0040); settle();
    chk("t1_gnt", mresp.gnt, 1);
    chk("t1_s1_req", sreq[1].req, 1);
    chk("t1_s0_req", sreq[0].req, 0);
    tick(); mset(1'b0, 1'b0, 32'h0); settle();
    chk("t1_outst1", outst, 1);
    tick(); srv(1, 32'hCAFE_0001); settle();
    chk("t1_rvalid", mresp.rvalid, 1);
    chk("t1_rdata", mresp.rdata, 32'hCAFE_0001);
    tick(); settle();
    chk("t1_outst0", outst, 0);

    // Back-to-back slave0 reads fill the outstanding window
    mset(1'b1, 1'b0, 32'h0000_0000); settle();
    chk("t2_gnt_a", mresp.gnt, 1);
    tick(); mset(1'b1, 1'b0, 32'h0000_0004); settle();
    chk("t2_gnt_b", mresp.gnt, 1);
    tick(); mset(1'b1, 1'b0, 32'h0000_0008); settle();
    chk("t2_full_gnt", mresp.gnt, 0);
    chk("t2_outst2", outst, 2);
    tick(); srv(0, 32'h0000_0011); settle();
    chk("t2_retire_gnt", mresp.gnt, 0);
    chk("t2_rdata_a", mresp.rdata, 32'h0000_0011);
    tick(); settle();
    chk("t2_gnt_c", mresp.gnt, 1);
    tick(); mset(1'b0, 1'b0, 32'h0); srv(0, 32'h0000_0022);
    tick(); srv(0, 32'h0000_0033);
    tick();

    // Slave2 then slave3: switch waits for slave2 to drain
    mset(1'b1, 1'b0, 32'h2000_0000); settle();
    chk("t3_gnt_s2", mresp.gnt, 1);
    tick(); mset(1'b1, 1'b0, 32'h3000_0000);
    tick(); tick(); tick();
    settle();
    chk("t3_s3_blocked", sreq[3].req, 0);
    tick(); srv(2, 32'h0000_2222); settle();
    chk("t3_s2_rdata", mresp.rdata, 32'h0000_2222);
    chk("t3_s3_still_blocked", sreq[3].req, 0);
    tick(); settle();
    chk("t3_s3_req", sreq[3].req, 1);
    tick(); mset(1'b0, 1'b0, 32'h0); srv(3, 32'h0000_3333); settle();
    chk("t3_s3_rdata", mresp.rdata, 32'h0000_3333);
    tick();

    // Unmapped write, then three consecutive unmapped requests
    mset(1'b1, 1'b1, 32'h4000_0000); settle();
    chk("t4_gnt", mresp.gnt, 1);
    chk("t4_err_pulse", err_un, 1);
    tick(); mset(1'b0, 1'b0, 32'h0); settle();
    chk("t4_rvalid", mresp.rvalid, 1);
    chk("t4_rdata", mresp.rdata, ERRD);
    chk("t4_err_done", err_un, 0);
    tick(); mset(1'b1, 1'b0, 32'h5000_0000);
    tick(); mset(1'b1, 1'b0, 32'h6000_0000); settle();
    chk("t4_b2b_gnt", mresp.gnt, 1);
    chk("t4_b2b_rvalid", mresp.rvalid, 1);
    tick(); mset(1'b1, 1'b1, 32'hF000_0000);
    tick(); mset(1'b0, 1'b0, 32'h0); settle();
    chk("t4_last_rvalid", mresp.rvalid, 1);
    tick();

    // Spurious slave1 rvalid with nothing outstanding, then while slave0 is the target
    srv(1, 32'hDEAD_0001); settle();
    chk("t5_idle_rvalid", mresp.rvalid, 0);
    tick(); mset(1'b1, 1'b0, 32'h0000_0010);
    tick(); mset(1'b0, 1'b0, 32'h0); srv(1, 32'hDEAD_0002); settle();
    chk("t5_wrong_slave_rvalid", mresp.rvalid, 0);
    chk("t5_outst", outst, 1);
    tick(); srv(0, 32'h0000_5555);
    tick();

    // Reset while a slave0 read is outstanding; the late response is dropped
    mset(1'b1, 1'b0, 32'h0000_0100);
    tick(); rst = 1'b1; settle();
    chk("t6_rst_gnt", mresp.gnt, 0);
    chk("t6_rst_s0_req", sreq[0].req, 0);
    tick(); rst = 1'b0; mset(1'b0, 1'b0, 32'h0); srv(0, 32'hDEAD_BEEF); settle();
    chk("t6_late_rvalid", mresp.rvalid, 0);
    chk("t6_outst", outst, 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
